// File: rtl/axi_read_arbiter_pkg.sv
// rtl/axi_read_arbiter_pkg.sv - shared constants for the AXI read arbiter
package axi_read_arbiter_pkg;

  localparam int ArbFixed = 0;
  localparam int ArbRR    = 1;

  localparam logic       RstEnable      = 1'b0;
  localparam logic [1:0] AxiRespOkay    = 2'b00;
  localparam logic [1:0] AxiBurstIncr   = 2'b01;
  localparam logic [2:0] AxiProtDefault = 3'b001;

  // Index width that stays legal for a single-entry vector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axi_read_arbiter_rr_arbiter.sv
// rtl/axi_read_arbiter_rr_arbiter.sv - one-hot grant, fixed priority or round-robin
module rr_arbiter
  import axi_read_arbiter_pkg::*;
#(
  parameter int N  = 2,
  parameter bit RR = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         update,
  output logic [N-1:0] grant
);

  localparam int            IW       = idx_w(N);
  localparam logic [IW-1:0] LastInit = IW'(N - 1);

  logic [IW-1:0] last_q;
  logic [IW-1:0] last_d;
  logic [IW-1:0] grant_idx;
  logic [IW-1:0] pick;
  logic          found;
  int            idx;

  // Round-robin search starts just past the last accepted port and wraps.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    pick      = '0;
    for (int k = 0; k < N; k++) begin
      idx  = RR ? (int'(last_q) + 1 + k) % N : k;
      pick = idx[IW-1:0];
      if (!found && req[pick]) begin
        found       = 1'b1;
        grant[pick] = 1'b1;
        grant_idx   = pick;
      end
    end
    last_d = (update && found) ? grant_idx : last_q;
  end

  always_ff @(posedge clk) begin
    if (reset == RstEnable) begin
      last_q <= LastInit;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// rtl/axi_read_arbiter.sv - multiplexes N read requesters onto one AXI3 AR/R pair
module axi_read_arbiter
  import axi_read_arbiter_pkg::*;
#(
  parameter int N_PORTS = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int ARB_RR  = ArbFixed
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_PORTS-1:0]        req_valid,
  input  logic [N_PORTS*ADDR_W-1:0] req_addr,
  output logic [N_PORTS-1:0]        req_ready,
  output logic [N_PORTS-1:0]        resp_valid,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      resp_err,
  input  logic [N_PORTS-1:0]        resp_ready,
  output logic [3:0]                arid,
  output logic [ADDR_W-1:0]         araddr,
  output logic [3:0]                arlen,
  output logic [2:0]                arsize,
  output logic [1:0]                arburst,
  output logic [1:0]                arlock,
  output logic [3:0]                arcache,
  output logic [2:0]                arprot,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [3:0]                rid,
  input  logic [DATA_W-1:0]         rdata,
  input  logic [1:0]                rresp,
  input  logic                      rlast,
  input  logic                      rvalid,
  output logic                      rready
);

  logic [N_PORTS-1:0] busy_q, busy_d;
  logic [N_PORTS-1:0] eligible, grant, accept, r_done;
  logic               arvalid_q, arvalid_d;
  logic [ADDR_W-1:0]  araddr_q, araddr_d;
  logic [3:0]         arid_q, arid_d;
  logic               slot_free;

  assign eligible  = req_valid & ~busy_q;
  assign slot_free = !arvalid_q || arready;
  assign accept    = slot_free ? grant : '0;
  assign req_ready = accept;

  rr_arbiter #(
    .N  (N_PORTS),
    .RR (ARB_RR == ArbRR)
  ) u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    (eligible),
    .update (|accept),
    .grant  (grant)
  );

  // Unmatched rid leaves rready at 1 so stray beats drain without a port.
  always_comb begin
    resp_valid = '0;
    rready     = 1'b1;
    r_done     = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (rid == 4'(i)) begin
        resp_valid[i] = rvalid;
        rready        = resp_ready[i];
        r_done[i]     = rvalid && resp_ready[i] && rlast;
      end
    end
  end

  always_comb begin
    araddr_d  = araddr_q;
    arid_d    = arid_q;
    arvalid_d = arvalid_q && !arready;
    for (int i = 0; i < N_PORTS; i++) begin
      if (accept[i]) begin
        araddr_d  = req_addr[i*ADDR_W +: ADDR_W];
        arid_d    = 4'(i);
        arvalid_d = 1'b1;
      end
    end
    busy_d = (busy_q & ~r_done) | accept;
  end

  always_ff @(posedge clk) begin
    if (reset == RstEnable) begin
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arid_q    <= '0;
      busy_q    <= '0;
    end else begin
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      arid_q    <= arid_d;
      busy_q    <= busy_d;
    end
  end

  assign arvalid   = arvalid_q;
  assign araddr    = araddr_q;
  assign arid      = arid_q;
  assign arlen     = 4'd0;
  assign arsize    = 3'($clog2(DATA_W / 8));
  assign arburst   = AxiBurstIncr;
  assign arlock    = 2'b00;
  assign arcache   = 4'b0000;
  assign arprot    = AxiProtDefault;
  assign resp_data = rdata;
  assign resp_err  = rresp != AxiRespOkay;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb/tb_axi_read_arbiter.sv - self-checking bench: fixed-priority N=2 and round-robin N=4 instances
module tb_axi_read_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // Instance a: N_PORTS=2, fixed priority
  logic [1:0]  a_req_valid, a_req_ready, a_resp_valid, a_resp_ready;
  logic [63:0] a_req_addr;
  logic [31:0] a_resp_data, a_araddr, a_rdata;
  logic        a_resp_err, a_arvalid, a_arready, a_rlast, a_rvalid, a_rready;
  logic [3:0]  a_arid, a_arlen, a_arcache, a_rid;
  logic [2:0]  a_arsize, a_arprot;
  logic [1:0]  a_arburst, a_arlock, a_rresp;

  // Instance b: N_PORTS=4, round-robin
  logic [3:0]   b_req_valid, b_req_ready, b_resp_valid, b_resp_ready;
  logic [127:0] b_req_addr;
  logic [31:0]  b_resp_data, b_araddr, b_rdata;
  logic         b_resp_err, b_arvalid, b_arready, b_rlast, b_rvalid, b_rready;
  logic [3:0]   b_arid, b_arlen, b_arcache, b_rid;
  logic [2:0]   b_arsize, b_arprot;
  logic [1:0]   b_arburst, b_arlock, b_rresp;

  axi_read_arbiter #(.N_PORTS(2), .ADDR_W(32), .DATA_W(32), .ARB_RR(0)) dut_a (
    .clk(clk), .reset(rst_n),
    .req_valid(a_req_valid), .req_addr(a_req_addr), .req_ready(a_req_ready),
    .resp_valid(a_resp_valid), .resp_data(a_resp_data), .resp_err(a_resp_err),
    .resp_ready(a_resp_ready),
    .arid(a_arid), .araddr(a_araddr), .arlen(a_arlen), .arsize(a_arsize),
    .arburst(a_arburst), .arlock(a_arlock), .arcache(a_arcache), .arprot(a_arprot),
    .arvalid(a_arvalid), .arready(a_arready),
    .rid(a_rid), .rdata(a_rdata), .rresp(a_rresp), .rlast(a_rlast),
    .rvalid(a_rvalid), .rready(a_rready)
  );

  axi_read_arbiter #(.N_PORTS(4), .ADDR_W(32), .DATA_W(32), .ARB_RR(1)) dut_b (
    .clk(clk), .reset(rst_n),
    .req_valid(b_req_valid), .req_addr(b_req_addr), .req_ready(b_req_ready),
    .resp_valid(b_resp_valid), .resp_data(b_resp_data), .resp_err(b_resp_err),
    .resp_ready(b_resp_ready),
    .arid(b_arid), .araddr(b_araddr), .arlen(b_arlen), .arsize(b_arsize),
    .arburst(b_arburst), .arlock(b_arlock), .arcache(b_arcache), .arprot(b_arprot),
    .arvalid(b_arvalid), .arready(b_arready),
    .rid(b_rid), .rdata(b_rdata), .rresp(b_rresp), .rlast(b_rlast),
    .rvalid(b_rvalid), .rready(b_rready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    #1;
    checks++;
    if (a_arvalid !== 1'b0 || a_araddr !== 32'h0 || a_arid !== 4'h0) begin
      failures++;
      $display("FAIL reset_a_ar got v=%b a=%h id=%h exp v=0 a=0 id=0", a_arvalid, a_araddr, a_arid);
    end
    checks++;
    if (b_arvalid !== 1'b0 || b_araddr !== 32'h0 || b_arid !== 4'h0) begin
      failures++;
      $display("FAIL reset_b_ar got v=%b a=%h id=%h exp v=0 a=0 id=0", b_arvalid, b_araddr, b_arid);
    end
    checks++;
    if ({a_arlen, a_arsize, a_arburst, a_arlock, a_arcache, a_arprot} !==
        {4'd0, 3'd2, 2'b01, 2'b00, 4'd0, 3'b001}) begin
      failures++;
      $display("FAIL const_ar got len=%h size=%h burst=%b lock=%b cache=%h prot=%b exp 0 2 01 00 0 001",
               a_arlen, a_arsize, a_arburst, a_arlock, a_arcache, a_arprot);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    a_req_valid = 2'b10;
    a_req_addr[32 +: 32] = 32'h0000_1000;
    a_arready = 1'b0;
    #1;
    checks++;
    if (a_req_ready !== 2'b10) begin
      failures++; $display("FAIL single_req_ready got=%b exp=10", a_req_ready);
    end
    tick();
    a_req_valid = 2'b00;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (a_arvalid !== 1'b1 || a_arid !== 4'd1 || a_araddr !== 32'h0000_1000) begin
        failures++;
        $display("FAIL single_ar_hold c=%0d got v=%b id=%h a=%h exp v=1 id=1 a=00001000", c, a_arvalid, a_arid, a_araddr);
      end
      if (c < 2) tick();
    end
    a_arready = 1'b1;
    tick();
    a_arready = 1'b0;
    #1;
    checks++;
    if (a_arvalid !== 1'b0) begin
      failures++; $display("FAIL single_ar_drop got=%b exp=0", a_arvalid);
    end
    a_rvalid = 1'b1; a_rid = 4'd1; a_rdata = 32'hDEAD_BEEF; a_rresp = 2'b00; a_rlast = 1'b1;
    a_resp_ready = 2'b10;
    a_req_valid = 2'b10;
    #1;
    checks++;
    if (a_resp_valid !== 2'b10 || a_resp_data !== 32'hDEAD_BEEF || a_rready !== 1'b1 || a_resp_err !== 1'b0) begin
      failures++;
      $display("FAIL single_resp got rv=%b d=%h rr=%b e=%b exp rv=10 d=deadbeef rr=1 e=0",
               a_resp_valid, a_resp_data, a_rready, a_resp_err);
    end
    checks++;
    if (a_req_ready !== 2'b00) begin
      failures++; $display("FAIL single_busy_same_cycle got=%b exp=00", a_req_ready);
    end
    tick();
    a_rvalid = 1'b0;
    #1;
    checks++;
    if (a_req_ready !== 2'b10) begin
      failures++; $display("FAIL single_regrant got=%b exp=10", a_req_ready);
    end
    a_req_valid = 2'b00;
  endtask

  task automatic issue_both();
    a_req_addr = {32'h0000_0200, 32'h0000_0100};
    a_req_valid = 2'b11;
    a_arready = 1'b1;
    #1;
    checks++;
    if (a_req_ready !== 2'b01) begin
      failures++; $display("FAIL prio_first got=%b exp=01", a_req_ready);
    end
    tick();
    #1;
    checks++;
    if (a_arid !== 4'd0 || a_araddr !== 32'h100 || a_arvalid !== 1'b1 || a_req_ready !== 2'b10) begin
      failures++;
      $display("FAIL prio_second got id=%h a=%h v=%b rdy=%b exp id=0 a=100 v=1 rdy=10", a_arid, a_araddr, a_arvalid, a_req_ready);
    end
    tick();
    #1;
    checks++;
    if (a_arid !== 4'd1 || a_araddr !== 32'h200 || a_req_ready !== 2'b00) begin
      failures++;
      $display("FAIL prio_third got id=%h a=%h rdy=%b exp id=1 a=200 rdy=00", a_arid, a_araddr, a_req_ready);
    end
    a_req_valid = 2'b00;
    tick();
    checks++;
    if (a_arvalid !== 1'b0) begin
      failures++; $display("FAIL prio_idle got=%b exp=0", a_arvalid);
    end
  endtask

  task automatic test_fixed_priority();
    issue_both();
    a_rvalid = 1'b1; a_rlast = 1'b1; a_rresp = 2'b00; a_resp_ready = 2'b11;
    a_rid = 4'd0;
    tick();
    a_rid = 4'd1;
    tick();
    a_rvalid = 1'b0;
  endtask

  task automatic test_out_of_order();
    issue_both();
    a_rvalid = 1'b1; a_rid = 4'd1; a_rdata = 32'hA1A1_0001; a_rresp = 2'b00; a_rlast = 1'b1;
    a_resp_ready = 2'b01;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (a_rready !== 1'b0 || a_resp_valid !== 2'b10) begin
        failures++;
        $display("FAIL ooo_stall c=%0d got rr=%b rv=%b exp rr=0 rv=10", c, a_rready, a_resp_valid);
      end
      tick();
    end
    a_resp_ready = 2'b11;
    #1;
    checks++;
    if (a_rready !== 1'b1 || a_resp_data !== 32'hA1A1_0001) begin
      failures++; $display("FAIL ooo_port1 got rr=%b d=%h exp rr=1 d=a1a10001", a_rready, a_resp_data);
    end
    tick();
    a_rid = 4'd0; a_rdata = 32'hB0B0_0000;
    #1;
    checks++;
    if (a_resp_valid !== 2'b01 || a_resp_data !== 32'hB0B0_0000 || a_rready !== 1'b1) begin
      failures++;
      $display("FAIL ooo_port0 got rv=%b d=%h rr=%b exp rv=01 d=b0b00000 rr=1", a_resp_valid, a_resp_data, a_rready);
    end
    tick();
    a_rvalid = 1'b0;
    a_req_valid = 2'b10;
    #1;
    checks++;
    if (a_req_ready !== 2'b10) begin
      failures++; $display("FAIL ooo_busy_clear got=%b exp=10", a_req_ready);
    end
    a_req_valid = 2'b00;
  endtask

  task automatic test_err_stray();
    a_req_addr[31:0] = 32'h0000_0300;
    a_req_valid = 2'b01;
    a_arready = 1'b1;
    tick();
    a_req_valid = 2'b00;
    tick();
    a_rvalid = 1'b1; a_rid = 4'd0; a_rresp = 2'b10; a_rlast = 1'b1; a_resp_ready = 2'b11;
    a_req_valid = 2'b01;
    #1;
    checks++;
    if (a_resp_err !== 1'b1 || a_resp_valid !== 2'b01 || a_req_ready !== 2'b00) begin
      failures++;
      $display("FAIL err_beat got e=%b rv=%b rdy=%b exp e=1 rv=01 rdy=00", a_resp_err, a_resp_valid, a_req_ready);
    end
    tick();
    a_req_valid = 2'b00;
    a_rid = 4'd7; a_rresp = 2'b00; a_resp_ready = 2'b00;
    #1;
    checks++;
    if (a_rready !== 1'b1 || a_resp_valid !== 2'b00 || a_resp_err !== 1'b0) begin
      failures++;
      $display("FAIL stray_rid got rr=%b rv=%b e=%b exp rr=1 rv=00 e=0", a_rready, a_resp_valid, a_resp_err);
    end
    tick();
    a_rvalid = 1'b0;
    a_req_valid = 2'b01;
    #1;
    checks++;
    if (a_req_ready !== 2'b01) begin
      failures++; $display("FAIL err_busy_clear got=%b exp=01", a_req_ready);
    end
    a_req_valid = 2'b00;
  endtask

  task automatic test_reset_mid();
    a_req_addr = {32'h0000_0600, 32'h0000_0500};
    a_req_valid = 2'b11;
    a_arready = 1'b1;
    tick();
    tick();
    a_req_valid = 2'b00;
    a_arready = 1'b0;
    #1;
    checks++;
    if (a_arvalid !== 1'b1 || a_arid !== 4'd1) begin
      failures++; $display("FAIL rstmid_pre got v=%b id=%h exp v=1 id=1", a_arvalid, a_arid);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (a_arvalid !== 1'b0 || a_araddr !== 32'h0 || a_arid !== 4'h0) begin
      failures++; $display("FAIL rstmid_ar got v=%b a=%h id=%h exp 0 0 0", a_arvalid, a_araddr, a_arid);
    end
    a_req_valid = 2'b11;
    #1;
    checks++;
    if (a_req_ready !== 2'b01) begin
      failures++; $display("FAIL rstmid_ready0 got=%b exp=01", a_req_ready);
    end
    a_req_valid = 2'b10;
    #1;
    checks++;
    if (a_req_ready !== 2'b10) begin
      failures++; $display("FAIL rstmid_ready1 got=%b exp=10", a_req_ready);
    end
    a_req_valid = 2'b00;
    tick();
  endtask

  task automatic test_rr_order();
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    b_req_valid = 4'b1111;
    b_req_addr = {32'h3000, 32'h2000, 32'h1000, 32'h0000};
    b_arready = 1'b1;
    b_resp_ready = 4'b1111;
    b_rlast = 1'b1; b_rresp = 2'b00;
    for (int k = 0; k < 5; k++) begin
      b_rvalid = (k > 0);
      b_rid = (k > 0) ? 4'(exp_order[k-1]) : 4'd0;
      #1;
      checks++;
      if (b_req_ready !== 4'(1 << exp_order[k])) begin
        failures++; $display("FAIL rr_grant k=%0d got=%b exp_port=%0d", k, b_req_ready, exp_order[k]);
      end
      tick();
      checks++;
      if (b_arid !== 4'(exp_order[k]) || b_arvalid !== 1'b1) begin
        failures++; $display("FAIL rr_arid k=%0d got id=%h v=%b exp id=%0d v=1", k, b_arid, b_arvalid, exp_order[k]);
      end
    end
    b_req_valid = 4'b0000;
    b_rvalid = 1'b1; b_rid = 4'd0;
    tick();
    b_rvalid = 1'b0;
  endtask

  // Reference: busy set per accepted port, cleared by its last beat; RR scans from last+1.
  task automatic test_random();
    bit [3:0]    mbusy;
    bit          mvalid;
    logic [31:0] maddr;
    int          mid, mlast, g, p;
    logic [3:0]  exp_rdy, exp_rv;
    logic        exp_rr, slot;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    mbusy = '0; mvalid = 1'b0; maddr = '0; mid = 0; mlast = 3;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      b_req_valid = 4'($urandom);
      for (int i = 0; i < 4; i++) b_req_addr[i*32 +: 32] = $urandom;
      b_arready = 1'($urandom_range(0, 1));
      b_rvalid = 1'($urandom_range(0, 1));
      b_rid = 4'($urandom_range(0, 7));
      b_rdata = $urandom;
      b_rresp = 2'($urandom);
      b_rlast = ($urandom_range(0, 3) != 0);
      b_resp_ready = 4'($urandom);
      #1;
      slot = !mvalid || b_arready;
      g = -1;
      for (int k = 0; k < 4; k++) begin
        p = (mlast + 1 + k) % 4;
        if (g < 0 && b_req_valid[p] && !mbusy[p]) g = p;
      end
      exp_rdy = (slot && g >= 0) ? 4'(1 << g) : 4'b0000;
      exp_rv = (b_rvalid && b_rid < 4) ? 4'(1 << b_rid) : 4'b0000;
      exp_rr = (b_rid < 4) ? b_resp_ready[b_rid[1:0]] : 1'b1;
      checks++;
      if (b_req_ready !== exp_rdy) begin
        failures++; $display("FAIL rand_req_ready cyc=%0d got=%b exp=%b", cyc, b_req_ready, exp_rdy);
      end
      checks++;
      if (b_arvalid !== mvalid || (mvalid && (b_araddr !== maddr || b_arid !== 4'(mid)))) begin
        failures++;
        $display("FAIL rand_ar cyc=%0d got v=%b a=%h id=%h exp v=%b a=%h id=%0d", cyc, b_arvalid, b_araddr, b_arid, mvalid, maddr, mid);
      end
      checks++;
      if (b_resp_valid !== exp_rv || b_rready !== exp_rr || b_resp_data !== b_rdata ||
          b_resp_err !== (b_rresp != 2'b00)) begin
        failures++;
        $display("FAIL rand_r cyc=%0d got rv=%b rr=%b e=%b exp rv=%b rr=%b", cyc, b_resp_valid, b_rready, b_resp_err, exp_rv, exp_rr);
      end
      if (b_rvalid && exp_rr && b_rlast && b_rid < 4) mbusy[b_rid[1:0]] = 1'b0;
      if (slot && g >= 0) begin
        mbusy[g] = 1'b1; mvalid = 1'b1; maddr = b_req_addr[g*32 +: 32]; mid = g; mlast = g;
      end else if (b_arready) begin
        mvalid = 1'b0;
      end
      tick();
    end
    b_req_valid = '0; b_rvalid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    a_req_valid = '0; a_req_addr = '0; a_resp_ready = '0; a_arready = 1'b0;
    a_rid = '0; a_rdata = '0; a_rresp = '0; a_rlast = 1'b0; a_rvalid = 1'b0;
    b_req_valid = '0; b_req_addr = '0; b_resp_ready = '0; b_arready = 1'b0;
    b_rid = '0; b_rdata = '0; b_rresp = '0; b_rlast = 1'b0; b_rvalid = 1'b0;
    test_reset();
    test_rr_order();
    test_single_read();
    test_fixed_priority();
    test_out_of_order();
    test_err_stray();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
